// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_pkg: shared state encoding and stream framing constants for the boot loader
package imem_boot_pkg;
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CSUM, VERIFY, DONE, ERROR} state_t;
  localparam int LEN_BYTES = 2;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte stream in, instruction-memory port out
interface imem_boot_loader_if;
  logic in_valid;
  logic in_ready;
  logic [7:0] in_data;
  logic mem_write_im;
  logic mem_read_im;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport master(input in_valid, in_data, mem_rdata,
                 output in_ready, mem_write_im, mem_read_im, mem_addr, mem_wdata);
  modport slave(output in_valid, in_data, mem_rdata,
                input in_ready, mem_write_im, mem_read_im, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_boot_loader_word_assembler.sv
// imem_word_assembler: packs little-endian bytes into a word, pulsing on the last byte of a field
module imem_word_assembler
  import imem_boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_i,
  input  logic        accept_i,
  input  logic        clear_i,
  input  logic        short_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);
  logic [1:0] cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d;
  // Newest byte enters at the top so a full field ends up little-endian; short fields sit in [31:16]
  always_comb begin
    word_o = {byte_i, sh_q[31:8]};
    word_valid_o = accept_i & (cnt_q == (short_i ? 2'(LEN_BYTES - 1) : 2'(WORD_BYTES - 1)));
    sh_d = accept_i ? word_o : sh_q;
    cnt_d = (clear_i | word_valid_o) ? 2'd0 : cnt_q + 2'(accept_i);
  end
  // Byte counter and shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sh_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q <= sh_d;
    end
  end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a length-prefixed image into instruction memory, verifies it, releases the CPU
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  imem_boot_loader_if.master bus,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [ADDR_W:0]    words_loaded
);
  localparam logic [15:0] MAX_N = 16'(DEPTH);
  state_t state_q, state_d;
  logic [ADDR_W:0] idx_q, n_q, words_q;
  logic [31:0] word_q, acc_q, csum_q, acc_nx, asm_word;
  logic [15:0] len;
  logic done_q, error_q, hold_q;
  logic go, accept, wv, last, wr, rd;
  imem_word_assembler u_asm (
    .clk(clk),
    .reset(reset),
    .byte_i(bus.in_data),
    .accept_i(accept),
    .clear_i(go),
    .short_i(state_q == LEN),
    .word_valid_o(wv),
    .word_o(asm_word)
  );
  assign bus.in_ready = state_q inside {LEN, DATA, CSUM};
  assign bus.mem_write_im = wr;
  assign bus.mem_read_im = rd;
  assign bus.mem_addr = (wr | rd) ? {{(32 - ADDR_W){1'b0}}, idx_q[ADDR_W-1:0]} : '0;
  assign bus.mem_wdata = wr ? word_q : '0;
  assign cpu_hold = hold_q;
  assign done = done_q;
  assign error = error_q;
  assign words_loaded = words_q;
  // Next-state logic; start is only honoured when the loader is not busy
  always_comb begin
    go = start & (state_q inside {IDLE, DONE, ERROR});
    accept = bus.in_valid & bus.in_ready;
    wr = state_q == WRITE;
    rd = state_q == VERIFY;
    last = (idx_q + 1'b1) == n_q;
    len = asm_word[31:16];
    acc_nx = acc_q ^ bus.mem_rdata;
    state_d = state_q;
    case (state_q)
      LEN:     state_d = wv ? ((len == '0 || len > MAX_N) ? ERROR : DATA) : LEN;
      DATA:    state_d = wv ? WRITE : DATA;
      WRITE:   state_d = last ? CSUM : DATA;
      CSUM:    state_d = wv ? VERIFY : CSUM;
      VERIFY:  state_d = last ? ((acc_nx == csum_q) ? DONE : ERROR) : VERIFY;
      default: state_d = go ? LEN : state_q;
    endcase
  end
  // State, counters, accumulators and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      n_q <= '0;
      words_q <= '0;
      word_q <= '0;
      acc_q <= '0;
      csum_q <= '0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      hold_q <= 1'b1;
    end else begin
      state_q <= state_d;
      done_q <= state_d == DONE;
      error_q <= state_d == ERROR;
      hold_q <= state_d != DONE;
      if (go) begin
        idx_q <= '0;
        words_q <= '0;
        acc_q <= '0;
      end
      if (state_q == LEN && wv) n_q <= len[ADDR_W:0];
      if (state_q == DATA && wv) word_q <= asm_word;
      if (wr) begin
        idx_q <= idx_q + 1'b1;
        words_q <= words_q + 1'b1;
      end
      if (state_q == CSUM && wv) begin
        csum_q <= asm_word;
        idx_q <= '0;
      end
      if (rd) begin
        acc_q <= acc_nx;
        idx_q <= idx_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed image loads against a queue-based model of expected writes and outcome
module tb_imem_boot_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic cpu_hold, done, error;
  logic [10:0] words_loaded;
  imem_boot_loader_if bus();
  imem_boot_loader dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bus(bus),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error),
    .words_loaded(words_loaded)
  );
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  assign bus.mem_rdata = bus.mem_read_im ? mem[bus.mem_addr[9:0]] : '0;
  always @(posedge clk) if (bus.mem_write_im) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;

  int total = 0;
  int bad = 0;
  int wr_n = 0;
  int rd_n = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] img[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (bus.mem_write_im || bus.mem_read_im)) begin
      chk("strobe_exclusive", 64'(bus.mem_write_im & bus.mem_read_im), 0);
      chk("addr_high_zero", 64'(bus.mem_addr[31:10]), 0);
      if (bus.mem_write_im) begin
        if (exp_addr_q.size() == 0) chk("write_unexpected", 1, 0);
        else begin
          chk("write_addr", bus.mem_addr, exp_addr_q.pop_front());
          chk("write_data", bus.mem_wdata, exp_data_q.pop_front());
        end
        chk("words_loaded_running", words_loaded, wr_n);
        wr_n++;
      end
      if (bus.mem_read_im) rd_n++;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wr_n = 0;
    rd_n = 0;
  endtask

  task automatic send(input logic [7:0] b, input bit rnd);
    bit ok = 1'b0;
    int t = 0;
    if (rnd) while ($urandom_range(1) == 0) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data = b;
    while (!ok) begin
      ok = bus.in_ready;
      @(posedge clk); #1;
      if (++t > 1000) begin
        chk("stream_timeout", 1, 0);
        ok = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], rnd);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 0);
    chk({tag, "_wr"}, 64'(bus.mem_write_im), 0);
    chk({tag, "_rd"}, 64'(bus.mem_read_im), 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_hold"}, 64'(cpu_hold), 1);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_error"}, 64'(error), 0);
    chk({tag, "_words"}, words_loaded, 0);
  endtask

  task automatic load(input logic [15:0] len, input bit rnd, input logic [31:0] flip, input string tag);
    logic [31:0] cs = '0;
    bit len_ok = len != 0 && len <= 16'd1024;
    bit ok = len_ok && flip == 0;
    int n = len_ok ? int'(len) : 0;
    pulse_start();
    chk({tag, "_hold_after_start"}, 64'(cpu_hold), 1);
    chk({tag, "_done_after_start"}, 64'(done), 0);
    send(len[7:0], 1'b0);
    send(len[15:8], 1'b0);
    if (len_ok) begin
      foreach (img[i]) begin
        exp_addr_q.push_back(32'(i));
        exp_data_q.push_back(img[i]);
        cs ^= img[i];
      end
      foreach (img[i]) send_word(img[i], rnd);
      send_word(cs ^ flip, 1'b0);
    end
    for (int t = 0; t < 4000 && !(done || error); t++) begin
      @(posedge clk); #1;
    end
    chk({tag, "_done"}, 64'(done), 64'(ok));
    chk({tag, "_error"}, 64'(error), 64'(!ok));
    chk({tag, "_hold"}, 64'(cpu_hold), 64'(!ok));
    chk({tag, "_words_loaded"}, words_loaded, n);
    chk({tag, "_write_count"}, wr_n, n);
    chk({tag, "_read_count"}, rd_n, n);
    chk({tag, "_writes_pending"}, exp_addr_q.size(), 0);
  endtask

  initial begin
    logic [31:0] x;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    check_reset("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset_start", 64'(bus.in_ready), 0);

    img = '{32'h11223344, 32'hA5A5A5A5, 32'h00000007};
    x = '0;
    foreach (img[i]) x ^= img[i];
    chk("csum_model", x, 32'hB48796E6);
    load(16'd3, 1'b0, 32'h0, "c1");
    chk("c1_mem0", mem[0], 32'h11223344);
    chk("c1_mem1", mem[1], 32'hA5A5A5A5);
    chk("c1_mem2", mem[2], 32'h00000007);

    load(16'd3, 1'b0, 32'h43000000, "c2");

    img = {};
    load(16'h0000, 1'b0, 32'h0, "c3_len0");
    load(16'h0401, 1'b0, 32'h0, "c3_len1025");

    mem[0] = '0;
    mem[1] = '0;
    mem[2] = '0;
    img = '{32'h11223344, 32'hA5A5A5A5, 32'h00000007};
    load(16'd3, 1'b1, 32'h0, "c4");
    chk("c4_mem0", mem[0], 32'h11223344);
    chk("c4_mem1", mem[1], 32'hA5A5A5A5);
    chk("c4_mem2", mem[2], 32'h00000007);

    pulse_start();
    send(8'd3, 1'b0);
    send(8'd0, 1'b0);
    exp_addr_q.push_back(32'd0);
    exp_data_q.push_back(32'hDEAD0001);
    exp_addr_q.push_back(32'd1);
    exp_data_q.push_back(32'hDEAD0002);
    send_word(32'hDEAD0001, 1'b0);
    send_word(32'hDEAD0002, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset("c5");
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("c5_write_count", wr_n, 2);
    chk("c5_writes_pending", exp_addr_q.size(), 0);
    chk("c5_mem0", mem[0], 32'hDEAD0001);
    chk("c5_mem1", mem[1], 32'hDEAD0002);
    chk("c5_mem2", mem[2], 32'h00000007);

    img = {};
    for (int i = 0; i < 1024; i++) img.push_back((32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000);
    load(16'd1024, 1'b0, 32'h0, "c6_full");
    chk("c6_mem0", mem[0], 32'h5A5A0000);
    chk("c6_mem1", mem[1], 32'hC46D79B9);
    chk("c6_mem1023", mem[1023], img[1023]);
    img = '{32'hCAFEF00D};
    load(16'd1, 1'b0, 32'h0, "c6_reload");
    chk("c6_reload_mem0", mem[0], 32'hCAFEF00D);
    chk("c6_reload_mem1", mem[1], 32'hC46D79B9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
